fetch_queue: RTL

Instruction prefetch queue directly upstream of the pipeline's IF/ID register. It replaces the single-cycle instruction-memory lookup with a request/acknowledge fetch engine that tolerates variable memory latency. Fetched instructions and their PCs are buffered in a small FIFO, and the head entry is presented to IF/ID. The hazard unit holds the head with `stall_i`; branch resolution flushes the queue and restarts fetch with `redirect_i`.

---
 rtl/fetch_queue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue feeding the IF/ID register.
// A single-outstanding request/acknowledge engine fills a DEPTH-entry FIFO
// of {pc, instr} pairs; the head entry is presented to the pipeline.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, an ack
// into an empty queue is forwarded straight to the outputs in the ack cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_data_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    input  logic                     stall_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t          r_state;
    logic            r_req;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_req_addr;
    logic [31:0]     r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    state_t          w_state_next;
    logic            w_ack;
    logic            w_ack_req;
    logic            w_empty;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_load_addr;
    logic [CW-1:0]   w_count_next;
    logic [31:0]     w_rpc;
    logic [31:0]     w_fetch_pc_next;
    logic [31:0]     w_req_addr_next;
    logic            w_unused_rpc_lsb;

    // The low two redirect bits are deliberately dropped (word-aligned fetch).
    assign w_rpc            = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_rpc_lsb = ^redirect_pc_i[1:0];

    // An ack only counts while a request is actually on the bus.
    assign w_ack     = imem_ack_i && r_req;
    // Ack of a live (non-draining) request that is not being flushed this cycle.
    assign w_ack_req = (r_state == S_REQ) && w_ack && !redirect_i;
    assign w_empty   = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: forward the acked word directly; it only enters the FIFO if held.
    assign w_bypass      = w_empty && w_ack_req;
    assign w_push        = w_ack_req && !(w_bypass && !stall_i);
    assign w_pop         = !w_empty && !stall_i && !redirect_i;
    assign instr_valid_o = !w_empty || w_bypass;
    assign instr_o       = !w_empty ? r_instr_mem[r_rd_ptr] : (w_bypass ? imem_data_i : NOP);
    assign pc_o          = !w_empty ? r_pc_mem[r_rd_ptr]    : (w_bypass ? r_req_addr  : 32'h0);
`else
    // Outputs come only from FIFO registers; no path from the memory side.
    assign w_bypass      = 1'b0;
    assign w_push        = w_ack_req;
    assign w_pop         = !w_empty && !stall_i && !redirect_i;
    assign instr_valid_o = !w_empty;
    assign instr_o       = !w_empty ? r_instr_mem[r_rd_ptr] : NOP;
    assign pc_o          = !w_empty ? r_pc_mem[r_rd_ptr]    : 32'h0;
`endif

    // A redirect empties the queue, so the occupancy it leaves behind is zero.
    assign w_count_next = redirect_i ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
    // Only issue when the word returned is guaranteed a free slot.
    assign w_issue      = start_i && (w_count_next < DEPTH_C);

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_req_addr;
    assign count_o     = r_count;

    // Request FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next != S_IDLE);
        end
    end

    // Next state: a request always runs to its ack; flushed requests drain first.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_issue) w_state_next = S_REQ;
            S_REQ: begin
                if (w_ack)           w_state_next = w_issue ? S_REQ : S_IDLE;
                else if (redirect_i) w_state_next = S_DRAIN;
            end
            S_DRAIN: if (w_ack) w_state_next = w_issue ? S_REQ : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: next fetch PC and the address latched when a new request issues.
    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (redirect_i)     w_fetch_pc_next = w_rpc;
        else if (w_ack_req) w_fetch_pc_next = r_fetch_pc + 32'd4;
        // Address changes only when a fresh request starts, keeping it stable until ack.
        w_load_addr     = (w_state_next == S_REQ) && ((r_state == S_IDLE) || w_ack);
        w_req_addr_next = w_load_addr ? w_fetch_pc_next : r_req_addr;
    end

    // Fetch/request address registers and FIFO control.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            r_req_addr <= w_req_addr_next;
            r_count    <= w_count_next;
            if (redirect_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful below r_count, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_req_addr;
            r_instr_mem[r_wr_ptr] <= imem_data_i;
        end
    end

endmodule
